// File: rtl/arrow_key_conditioner.sv
// Arrow push-button conditioner: 2-flop synchroniser, per-key debounce, one-hot
// press pulses with UP > DOWN > LEFT > RIGHT priority and auto-repeat on held keys.
module arrow_key_conditioner #(
   parameter int unsigned DEBOUNCE_CYC  = 1000000,
   parameter int unsigned REPEAT_DELAY  = 50000000,
   parameter int unsigned REPEAT_PERIOD = 15000000,
   parameter logic [3:0]  REPEAT_MASK   = 4'b1100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] raw_keys,
   output logic [3:0] arrow_keys,
   output logic [3:0] key_held
);

   localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC);
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned REP_W   = $clog2(REP_MAX);

   localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

   localparam logic [0:0] PH_DELAY  = 1'b0;
   localparam logic [0:0] PH_PERIOD = 1'b1;

   logic [3:0]            sync1;
   logic [3:0]            sync2;
   logic [3:0]            db_prev;
   logic [3:0][DB_W-1:0]  db_cnt;
   logic [REP_W-1:0]      rep_cnt;
   logic [0:0]            phase;

   logic [3:0]            rise;
   logic [3:0]            rep_fire;
   logic [3:0]            req;
   logic [3:0]            pulse_next;
   logic                  armed;
   logic                  held_change;
   logic                  rep_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= '0;
         sync2   <= '0;
         db_prev <= '0;
      end else begin
         sync1   <= raw_keys;
         sync2   <= sync1;
         db_prev <= key_held;
      end
   end

   // Any cycle where sync agrees with the debounced level restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt   <= '0;
         key_held <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] != key_held[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  key_held[i] <= sync2[i];
                  db_cnt[i]   <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + DB_W'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   always_comb begin
      rise        = key_held & ~db_prev;
      held_change = (key_held != db_prev);
      armed       = en && $onehot(key_held) && ((key_held & REPEAT_MASK) != 4'b0000);
      rep_hit     = (phase == PH_DELAY) ? (rep_cnt == DELAY_LAST) : (rep_cnt == PERIOD_LAST);
      // A change of key_held restarts the repeat timer, so a rise never meets a fire.
      rep_fire    = (armed && !held_change && rep_hit) ? key_held : 4'b0000;
      req         = rise | rep_fire;
      pulse_next  = 4'b0000;
      if (req[3])      pulse_next = 4'b1000;
      else if (req[2]) pulse_next = 4'b0100;
      else if (req[1]) pulse_next = 4'b0010;
      else if (req[0]) pulse_next = 4'b0001;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt <= '0;
         phase   <= PH_DELAY;
      end else if (!armed || held_change) begin
         rep_cnt <= '0;
         phase   <= PH_DELAY;
      end else if (rep_hit) begin
         rep_cnt <= '0;
         phase   <= PH_PERIOD;
      end else begin
         rep_cnt <= rep_cnt + REP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arrow_keys <= '0;
      end else begin
         arrow_keys <= en ? pulse_next : 4'b0000;
      end
   end

endmodule

// File: tb/tb_arrow_key_conditioner.sv
// Bench for arrow_key_conditioner: directed timing scenarios plus random key
// activity, every cycle compared against a timeline-based reference model.
module tb_arrow_key_conditioner;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 5;
   localparam logic [3:0] MASK = 4'b1100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [3:0] raw_keys = 4'b0000;
   logic [3:0] arrow_keys;
   logic [3:0] key_held;

   always #5 clk = ~clk;

   arrow_key_conditioner #(
      .DEBOUNCE_CYC (DB),
      .REPEAT_DELAY (RD),
      .REPEAT_PERIOD(RP),
      .REPEAT_MASK  (MASK)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .raw_keys  (raw_keys),
      .arrow_keys(arrow_keys),
      .key_held  (key_held)
   );

   int n_checks = 0;
   int n_pass = 0;
   int pulse_cnt = 0;
   logic [3:0] last_pulse = 4'b0000;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
   endtask

   // Reference model: raw history, mismatch run lengths, and time since arming.
   logic [3:0] m_hist [2];
   logic [3:0] m_db, m_dbp, m_out;
   int         m_run [4];
   int         m_t;

   task automatic model_reset();
      m_hist[0] = '0; m_hist[1] = '0;
      m_db = '0; m_dbp = '0; m_out = '0; m_t = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
   endtask

   task automatic model_step();
      logic [3:0] want, fire, db_n;
      logic       armed, found;
      fire  = '0;
      armed = en && $onehot(m_db) && ((m_db & MASK) != 4'b0000);
      if (!armed || (m_db != m_dbp)) begin
         m_t = 0;
      end else begin
         if (m_t == RD - 1 || (m_t > RD - 1 && (m_t - (RD - 1)) % RP == 0)) fire = m_db;
         m_t++;
      end
      want  = (m_db & ~m_dbp) | fire;
      m_out = '0;
      found = 1'b0;
      if (en) begin
         for (int i = 3; i >= 0; i--) begin
            if (want[i] && !found) begin
               m_out = 4'(1 << i);
               found = 1'b1;
            end
         end
      end
      db_n = m_db;
      for (int i = 0; i < 4; i++) begin
         if (m_hist[1][i] != m_db[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
               db_n[i]  = m_hist[1][i];
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_dbp     = m_db;
      m_db      = db_n;
      m_hist[1] = m_hist[0];
      m_hist[0] = raw_keys;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("arrow_keys_vs_model", arrow_keys, m_out);
            check("key_held_vs_model", key_held, m_db);
            check("onehot0", {3'b000, $onehot0(arrow_keys)}, 4'b0001);
            if (arrow_keys != 4'b0000) begin
               pulse_cnt++;
               last_pulse = arrow_keys;
            end
         end
      end
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic count_window(input logic [3:0] keys, input int n, input int exp_cnt, input string tag);
      @(negedge clk);
      pulse_cnt = 0;
      raw_keys  = keys;
      wait_neg(n);
      check(tag, 4'(pulse_cnt), 4'(exp_cnt));
      raw_keys = 4'b0000;
      wait_neg(14);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_arrow_keys", arrow_keys, 4'b0000);
      check("reset_key_held", key_held, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
      wait_neg(4);

      // Clean press of UP
      raw_keys = 4'b1000;
      wait_neg(5);
      check("press_held_before_edge6", key_held, 4'b0000);
      wait_neg(1);
      check("press_held_edge6", key_held, 4'b1000);
      check("press_no_pulse_edge6", arrow_keys, 4'b0000);
      wait_neg(1);
      check("press_pulse_edge7", arrow_keys, 4'b1000);
      wait_neg(1);
      check("press_pulse_gone_edge8", arrow_keys, 4'b0000);
      raw_keys = 4'b0000;
      wait_neg(5);
      check("release_held_edge5", key_held, 4'b1000);
      wait_neg(1);
      check("release_held_edge6", key_held, 4'b0000);
      wait_neg(8);

      // Bounce
      pulse_cnt = 0;
      raw_keys = 4'b1000; wait_neg(1);
      raw_keys = 4'b0000; wait_neg(1);
      raw_keys = 4'b1000; wait_neg(1);
      raw_keys = 4'b0000; wait_neg(1);
      raw_keys = 4'b1000;
      wait_neg(6);
      check("bounce_no_early_pulse", 4'(pulse_cnt), 4'd0);
      wait_neg(1);
      check("bounce_pulse_edge7", arrow_keys, 4'b1000);
      raw_keys = 4'b0000;
      wait_neg(14);
      check("bounce_single_pulse", 4'(pulse_cnt), 4'd1);

      // Auto-repeat on DOWN: press at edge 7, repeats at 17,22,...,47
      count_window(4'b0100, 48, 8, "repeat_down_count");
      count_window(4'b0010, 48, 1, "no_repeat_left_count");
      count_window(4'b1001, 48, 1, "simultaneous_count");
      check("simultaneous_is_up", last_pulse, 4'b1000);

      // Enable low while UP debounces, then raise en
      en = 1'b0;
      pulse_cnt = 0;
      raw_keys = 4'b1000;
      wait_neg(20);
      check("en_low_no_pulse", 4'(pulse_cnt), 4'd0);
      check("en_low_held_valid", key_held, 4'b1000);
      en = 1'b1;
      wait_neg(9);
      check("en_rise_no_early_pulse", 4'(pulse_cnt), 4'd0);
      wait_neg(1);
      check("en_first_repeat", arrow_keys, 4'b1000);
      raw_keys = 4'b0000;
      wait_neg(14);

      // Reset mid-operation with UP held and repeat counter at 6
      raw_keys = 4'b1000;
      wait_neg(13);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset_arrow", arrow_keys, 4'b0000);
      check("async_reset_held", key_held, 4'b0000);
      wait_neg(2);
      rst_n = 1'b1;
      wait_neg(6);
      check("post_reset_no_pulse_edge6", arrow_keys, 4'b0000);
      wait_neg(1);
      check("post_reset_pulse_edge7", arrow_keys, 4'b1000);
      raw_keys = 4'b0000;
      wait_neg(14);

      // Random key activity against the model
      for (int it = 0; it < 200; it++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel <= 5) raw_keys = 4'(1 << $urandom_range(0, 3));
         else if (sel == 7) raw_keys = 4'($urandom_range(0, 15));
         else raw_keys = 4'b0000;
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 49) == 0) begin
            #2 rst_n = 1'b0;
            wait_neg(2);
            rst_n = 1'b1;
         end
         wait_neg($urandom_range(1, 25));
      end

      raw_keys = 4'b0000;
      en = 1'b1;
      wait_neg(20);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
